// File: rtl/cache_line_filler_pkg.sv
// Shared definitions for the cache line filler: default geometry, the
// line/word split of a RAM word address, and the refill FSM encoding.
package cache_line_filler_pkg;

  // Default geometry; modules take these as parameter defaults.
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_LINE_LOG2  = 2;
  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_MEM_AW     = 32;

  localparam int LINE_WORDS     = 1 << DEF_LINE_LOG2;
  localparam int BYTES_PER_WORD = DEF_DATA_WIDTH / 8;

  // Same derivations for a non-default geometry.
  function automatic int line_words(input int line_log2);
    return 1 << line_log2;
  endfunction

  function automatic int bytes_per_word(input int data_width);
    return data_width / 8;
  endfunction

  // A RAM word address is {line index, word-in-line}; the line field is the
  // upper ADDR_WIDTH-LINE_LOG2 bits, the word field the low LINE_LOG2 bits.
  typedef struct packed {
    logic [DEF_ADDR_WIDTH-DEF_LINE_LOG2-1:0] line;
    logic [DEF_LINE_LOG2-1:0]                word;
  } ram_addr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } fill_state_t;

endpackage

// File: rtl/cache_line_filler_if.sv
// Bundle of the filler's request, backing-memory, RAM and lookup signals.
// master = the filler controller, slave = everything around it.
interface cache_line_filler_if
  import cache_line_filler_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_LOG2  = DEF_LINE_LOG2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_AW     = DEF_MEM_AW
) ();

  // refill request
  logic                            fill_req;
  logic [ADDR_WIDTH-LINE_LOG2-1:0] fill_line;
  logic [MEM_AW-1:0]               fill_mem_addr;
  logic                            fill_ready;
  logic                            fill_done;
  // backing memory
  logic                            mem_valid;
  logic [MEM_AW-1:0]               mem_addr;
  logic                            mem_ready;
  logic [DATA_WIDTH-1:0]           mem_rdata;
  // data RAM
  logic                            ram_we;
  logic [ADDR_WIDTH-1:0]           ram_waddr;
  logic [DATA_WIDTH-1:0]           ram_wdata;
  logic                            ram_re;
  logic [ADDR_WIDTH-1:0]           ram_raddr;
  logic [DATA_WIDTH-1:0]           ram_rdata;
  // lookup client
  logic                            rd_req;
  logic [ADDR_WIDTH-1:0]           rd_addr;
  logic                            rd_gnt;
  logic                            rd_valid;
  logic [DATA_WIDTH-1:0]           rd_data;

  modport master (
    input  fill_req, fill_line, fill_mem_addr, mem_ready, mem_rdata,
           ram_rdata, rd_req, rd_addr,
    output fill_ready, fill_done, mem_valid, mem_addr,
           ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
           rd_gnt, rd_valid, rd_data
  );

  modport slave (
    output fill_req, fill_line, fill_mem_addr, mem_ready, mem_rdata,
           ram_rdata, rd_req, rd_addr,
    input  fill_ready, fill_done, mem_valid, mem_addr,
           ram_we, ram_waddr, ram_wdata, ram_re, ram_raddr,
           rd_gnt, rd_valid, rd_data
  );

endinterface

// File: rtl/cache_read_gate.sv
// Read-port gate: stalls lookups of line words the refill has not written
// yet, and produces the registered read-valid.
module cache_read_gate #(
  parameter int ADDR_WIDTH = 4,
  parameter int LINE_LOG2  = 2
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            i_fetch,
  input  logic [ADDR_WIDTH-LINE_LOG2-1:0] i_line,
  input  logic [LINE_LOG2-1:0]            i_cnt,
  input  logic                            i_mem_ready,
  input  logic                            i_rd_req,
  input  logic [ADDR_WIDTH-1:0]           i_rd_addr,
  output logic                            o_rd_gnt,
  output logic                            o_ram_re,
  output logic                            o_rd_valid
);

  logic [ADDR_WIDTH-LINE_LOG2-1:0] w_rd_line;
  logic [LINE_LOG2-1:0]            w_rd_word;
  logic                            w_stall;
  logic                            r_rd_valid;

  assign w_rd_line = i_rd_addr[ADDR_WIDTH-1:LINE_LOG2];
  assign w_rd_word = i_rd_addr[LINE_LOG2-1:0];

  // Stall only words of the line in flight that are not yet in the RAM; the
  // word landing this cycle is already readable because the RAM registers
  // the read address and returns the freshly written data next cycle.
  always_comb begin
    w_stall = i_fetch && (w_rd_line == i_line) &&
              ((w_rd_word > i_cnt) || ((w_rd_word == i_cnt) && !i_mem_ready));
  end

  assign o_rd_gnt   = !w_stall;
  assign o_ram_re   = i_rd_req && !w_stall && !reset;
  assign o_rd_valid = r_rd_valid;

  // Read data follows an accepted read by exactly one cycle.
  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignment so every flop samples
    // pre-edge values regardless of block ordering.
    if (reset) r_rd_valid <= 1'b0;
    else       r_rd_valid <= i_rd_req && !w_stall;
  end

endmodule

// File: rtl/cache_line_filler.sv
// Cache line filler: refills one RAM line from backing memory word by word
// and arbitrates the RAM read port for the lookup client.
module cache_line_filler
  import cache_line_filler_pkg::*;
#(
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int LINE_LOG2  = DEF_LINE_LOG2,
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int MEM_AW     = DEF_MEM_AW
) (
  input  logic                clk,
  input  logic                reset,
  cache_line_filler_if.master bus
);

  localparam int LINE_AW = ADDR_WIDTH - LINE_LOG2;
  localparam int BPW     = bytes_per_word(DATA_WIDTH);
  localparam logic [LINE_LOG2-1:0] CNT_MAX = LINE_LOG2'(line_words(LINE_LOG2) - 1);

  fill_state_t          r_state, w_state_nxt;
  logic [LINE_AW-1:0]   r_line;
  logic [MEM_AW-1:0]    r_base;
  logic [LINE_LOG2-1:0] r_cnt;

  logic                 w_fill_ready;
  logic                 w_fill_done;
  logic                 w_mem_valid;
  logic                 w_ram_we;
  logic [MEM_AW-1:0]    w_mem_addr;

  // Word byte address; the sum wraps at MEM_AW bits.
  assign w_mem_addr = r_base + MEM_AW'(r_cnt) * MEM_AW'(BPW);

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Latch the request on acceptance; advance the word counter per handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt  <= '0;
      r_line <= '0;
      r_base <= '0;
    end else if (r_state == IDLE && bus.fill_req) begin
      r_line <= bus.fill_line;
      r_base <= bus.fill_mem_addr;
      r_cnt  <= '0;
    end else if (w_ram_we) begin
      r_cnt  <= r_cnt + 1'b1;
    end
  end

  // Next state and handshake outputs; writes are suppressed during reset.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned
    // and no latch is inferred.
    w_state_nxt  = r_state;
    w_fill_ready = 1'b0;
    w_fill_done  = 1'b0;
    w_mem_valid  = 1'b0;
    w_ram_we     = 1'b0;
    unique case (r_state)
      IDLE: begin
        w_fill_ready = 1'b1;
        if (bus.fill_req) w_state_nxt = FETCH;
      end
      FETCH: begin
        w_mem_valid = 1'b1;
        if (bus.mem_ready) begin
          w_ram_we = !reset;
          if (r_cnt == CNT_MAX) w_state_nxt = DONE;
        end
      end
      DONE: begin
        w_fill_done = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign bus.fill_ready = w_fill_ready;
  assign bus.fill_done  = w_fill_done;
  assign bus.mem_valid  = w_mem_valid;
  assign bus.mem_addr   = w_mem_addr;
  assign bus.ram_we     = w_ram_we;
  assign bus.ram_waddr  = {r_line, r_cnt};
  assign bus.ram_wdata  = bus.mem_rdata;
  assign bus.ram_raddr  = bus.rd_addr;
  assign bus.rd_data    = bus.ram_rdata;

  cache_read_gate #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LINE_LOG2  (LINE_LOG2)
  ) u_read_gate (
    .clk         (clk),
    .reset       (reset),
    .i_fetch     (r_state == FETCH),
    .i_line      (r_line),
    .i_cnt       (r_cnt),
    .i_mem_ready (bus.mem_ready),
    .i_rd_req    (bus.rd_req),
    .i_rd_addr   (bus.rd_addr),
    .o_rd_gnt    (bus.rd_gnt),
    .o_ram_re    (bus.ram_re),
    .o_rd_valid  (bus.rd_valid)
  );

endmodule

// File: tb/tb_cache_line_filler.sv
// Directed bench for cache_line_filler: behavioural dual-port RAM and a
// backing memory whose data is its address XOR a per-test seed.
module tb_cache_line_filler;
  import cache_line_filler_pkg::*;

  localparam int AW = 4;
  localparam int LL = 2;
  localparam int DW = 32;
  localparam int MA = 32;

  logic clk = 1'b0;
  logic reset;
  logic [31:0] seed;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cache_line_filler_if #(.ADDR_WIDTH(AW), .LINE_LOG2(LL), .DATA_WIDTH(DW), .MEM_AW(MA)) bus ();

  cache_line_filler #(.ADDR_WIDTH(AW), .LINE_LOG2(LL), .DATA_WIDTH(DW), .MEM_AW(MA)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  // RAM: word i starts as i*0x11111111; read address is registered.
  logic [31:0] ram [16] = '{32'h00000000, 32'h11111111, 32'h22222222, 32'h33333333,
                            32'h44444444, 32'h55555555, 32'h66666666, 32'h77777777,
                            32'h88888888, 32'h99999999, 32'hAAAAAAAA, 32'hBBBBBBBB,
                            32'hCCCCCCCC, 32'hDDDDDDDD, 32'hEEEEEEEE, 32'hFFFFFFFF};
  logic [3:0] r_raddr = '0;

  always @(posedge clk) begin
    if (bus.ram_we) ram[bus.ram_waddr] <= bus.ram_wdata;
    if (bus.ram_re) r_raddr <= bus.ram_raddr;
  end

  assign bus.ram_rdata = ram[r_raddr];
  assign bus.mem_rdata = bus.mem_addr ^ seed;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ seed;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic rd_check(input string tag, input logic [3:0] a, input logic [31:0] exp);
    tick();
    bus.rd_req  = 1'b1;
    bus.rd_addr = a;
    settle();
    check({tag, "_gnt"}, 32'(bus.rd_gnt), 32'd1);
    tick();
    bus.rd_req = 1'b0;
    settle();
    check({tag, "_valid"}, 32'(bus.rd_valid), 32'd1);
    check({tag, "_data"}, bus.rd_data, exp);
  endtask

  task automatic wait_fill_done(input string tag, input int budget);
    logic found;
    found = 1'b0;
    for (int n = 0; n < budget && !found; n++) begin
      tick();
      settle();
      if (bus.fill_done) found = 1'b1;
    end
    check(tag, 32'(found), 32'd1);
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] base;
    int k;
    int we_cnt;
    logic got_done;

    reset             = 1'b1;
    seed              = '0;
    bus.fill_req      = 1'b0;
    bus.fill_line     = '0;
    bus.fill_mem_addr = '0;
    bus.mem_ready     = 1'b0;
    bus.rd_req        = 1'b0;
    bus.rd_addr       = '0;

    // ---------------- reset state
    tick();
    tick();
    reset = 1'b0;
    settle();
    check("rst_fill_ready", 32'(bus.fill_ready), 32'd1);
    check("rst_fill_done",  32'(bus.fill_done),  32'd0);
    check("rst_mem_valid",  32'(bus.mem_valid),  32'd0);
    check("rst_rd_valid",   32'(bus.rd_valid),   32'd0);
    check("rst_ram_we",     32'(bus.ram_we),     32'd0);
    check("rst_ram_re",     32'(bus.ram_re),     32'd0);

    // ---------------- T1: line 2 from 0x100, mem_ready tied high
    tick();
    seed              = 32'h1111_0000;
    bus.fill_line     = 2'd2;
    bus.fill_mem_addr = 32'h100;
    bus.mem_ready     = 1'b1;
    bus.fill_req      = 1'b1;
    settle();
    check("t1_accept_ready", 32'(bus.fill_ready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.fill_req = 1'b0;
      settle();
      check("t1_mem_valid", 32'(bus.mem_valid), 32'd1);
      check("t1_mem_addr",  bus.mem_addr, 32'h100 + 32'(4 * i));
      check("t1_ram_we",    32'(bus.ram_we), 32'd1);
      check("t1_ram_waddr", 32'(bus.ram_waddr), 32'(8 + i));
      check("t1_ram_wdata", bus.ram_wdata, word_of(32'h100 + 32'(4 * i)));
      check("t1_fill_ready_low", 32'(bus.fill_ready), 32'd0);
      check("t1_no_early_done",  32'(bus.fill_done), 32'd0);
    end
    tick();
    settle();
    check("t1_fill_done",     32'(bus.fill_done),  32'd1);
    check("t1_done_mem_valid", 32'(bus.mem_valid), 32'd0);
    check("t1_done_not_ready", 32'(bus.fill_ready), 32'd0);
    tick();
    settle();
    check("t1_done_pulse",  32'(bus.fill_done),  32'd0);
    check("t1_back_ready",  32'(bus.fill_ready), 32'd1);

    // ---------------- T2: mem_ready every third cycle, line 2 from 0x200
    tick();
    seed              = 32'h2222_0000;
    base              = 32'h200;
    bus.fill_mem_addr = base;
    bus.fill_line     = 2'd2;
    bus.mem_ready     = 1'b0;
    bus.fill_req      = 1'b1;
    settle();
    k        = 0;
    we_cnt   = 0;
    got_done = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      tick();
      bus.fill_req  = 1'b0;
      bus.mem_ready = (c % 3 == 2);
      settle();
      if (bus.fill_done) begin
        got_done = 1'b1;
      end else begin
        check("t2_mem_valid", 32'(bus.mem_valid), 32'd1);
        check("t2_mem_addr",  bus.mem_addr, base + 32'(4 * k));
        check("t2_ram_we",    32'(bus.ram_we), 32'(bus.mem_ready));
        if (bus.ram_we) we_cnt++;
        if (bus.mem_ready) begin
          check("t2_ram_waddr", 32'(bus.ram_waddr), 32'(8 + k));
          k++;
        end
      end
    end
    bus.mem_ready = 1'b0;
    check("t2_done_seen", 32'(got_done), 32'd1);
    check("t2_we_count",  32'(we_cnt), 32'd4);
    tick();
    for (int i = 0; i < 4; i++)
      rd_check("t2_readback", 4'(8 + i), 32'h2222_0200 + 32'(4 * i));

    // ---------------- T3: read stall on the line being refilled (line 2, 0x300)
    tick();
    seed              = 32'h3333_0000;
    bus.fill_mem_addr = 32'h300;
    bus.fill_line     = 2'd2;
    bus.mem_ready     = 1'b0;
    bus.fill_req      = 1'b1;
    settle();
    tick();                                       // cnt=0, word 0 lands
    bus.fill_req  = 1'b0;
    bus.mem_ready = 1'b1;
    settle();
    check("t3_w0_waddr", 32'(bus.ram_waddr), 32'd8);
    tick();                                       // cnt=1, other-line read
    bus.mem_ready = 1'b0;
    bus.rd_req    = 1'b1;
    bus.rd_addr   = 4'd3;
    settle();
    check("t3_other_line_gnt", 32'(bus.rd_gnt), 32'd1);
    tick();                                       // cnt=1, word 1 lands, read 10
    bus.mem_ready = 1'b1;
    bus.rd_addr   = 4'd10;
    settle();
    check("t3_other_valid",  32'(bus.rd_valid), 32'd1);
    check("t3_other_data",   bus.rd_data, 32'h3333_3333);
    check("t3_ahead_gnt",    32'(bus.rd_gnt), 32'd0);
    check("t3_ahead_re",     32'(bus.ram_re), 32'd0);
    check("t3_w1_waddr",     32'(bus.ram_waddr), 32'd9);
    tick();                                       // cnt=2, no handshake
    bus.mem_ready = 1'b0;
    settle();
    check("t3_stall_valid",  32'(bus.rd_valid), 32'd0);
    check("t3_equal_gnt",    32'(bus.rd_gnt), 32'd0);
    tick();                                       // cnt=2, word 2 lands
    bus.mem_ready = 1'b1;
    settle();
    check("t3_land_gnt",     32'(bus.rd_gnt), 32'd1);
    check("t3_land_re",      32'(bus.ram_re), 32'd1);
    check("t3_land_we",      32'(bus.ram_we), 32'd1);
    check("t3_land_waddr",   32'(bus.ram_waddr), 32'd10);
    tick();                                       // cnt=3, word 3 lands
    bus.rd_req = 1'b0;
    settle();
    check("t3_new_valid",    32'(bus.rd_valid), 32'd1);
    check("t3_new_data",     bus.rd_data, 32'h3333_0308);
    check("t3_w3_waddr",     32'(bus.ram_waddr), 32'd11);
    tick();
    bus.mem_ready = 1'b0;
    settle();
    check("t3_fill_done",    32'(bus.fill_done), 32'd1);

    // ---------------- T4: fill_req held through a fill is not queued
    tick();
    seed              = 32'h4444_0000;
    bus.fill_line     = 2'd3;
    bus.fill_mem_addr = 32'h400;
    bus.mem_ready     = 1'b1;
    bus.fill_req      = 1'b1;
    settle();
    check("t4_accept", 32'(bus.fill_ready), 32'd1);
    tick();
    bus.fill_line     = 2'd1;
    bus.fill_mem_addr = 32'h500;
    settle();
    check("t4_busy_ready", 32'(bus.fill_ready), 32'd0);
    check("t4_addr0",      bus.mem_addr, 32'h400);
    check("t4_waddr0",     32'(bus.ram_waddr), 32'd12);
    for (int i = 1; i < 4; i++) begin
      tick();
      settle();
      check("t4_addr",  bus.mem_addr, 32'h400 + 32'(4 * i));
      check("t4_waddr", 32'(bus.ram_waddr), 32'(12 + i));
      check("t4_busy",  32'(bus.fill_ready), 32'd0);
    end
    tick();
    settle();
    check("t4_done",       32'(bus.fill_done),  32'd1);
    check("t4_done_ready", 32'(bus.fill_ready), 32'd0);
    tick();
    settle();
    check("t4_idle_ready", 32'(bus.fill_ready), 32'd1);
    check("t4_idle_valid", 32'(bus.mem_valid),  32'd0);
    tick();
    bus.fill_req = 1'b0;
    settle();
    check("t4_second_valid", 32'(bus.mem_valid), 32'd1);
    check("t4_second_addr",  bus.mem_addr, 32'h500);
    check("t4_second_waddr", 32'(bus.ram_waddr), 32'd4);
    wait_fill_done("t4_second_done", 10);
    tick();

    // ---------------- T5: reset at cnt=2 aborts the fill (line 0, 0x600)
    seed              = 32'h5555_0000;
    bus.fill_line     = 2'd0;
    bus.fill_mem_addr = 32'h600;
    bus.mem_ready     = 1'b1;
    bus.fill_req      = 1'b1;
    settle();
    tick();
    bus.fill_req = 1'b0;
    settle();
    check("t5_w0_waddr", 32'(bus.ram_waddr), 32'd0);
    tick();
    settle();
    check("t5_w1_waddr", 32'(bus.ram_waddr), 32'd1);
    tick();
    reset = 1'b1;
    settle();
    check("t5_we_in_reset", 32'(bus.ram_we), 32'd0);
    tick();
    reset = 1'b0;
    settle();
    check("t5_after_valid", 32'(bus.mem_valid),  32'd0);
    check("t5_after_ready", 32'(bus.fill_ready), 32'd1);
    check("t5_after_we",    32'(bus.ram_we),     32'd0);
    for (int i = 0; i < 6; i++) begin
      tick();
      settle();
      check("t5_no_done",  32'(bus.fill_done), 32'd0);
      check("t5_idle_mem", 32'(bus.mem_valid), 32'd0);
    end
    tick();
    bus.fill_line     = 2'd1;
    bus.fill_mem_addr = 32'h700;
    bus.fill_req      = 1'b1;
    settle();
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.fill_req = 1'b0;
      settle();
      check("t5_refill_addr",  bus.mem_addr, 32'h700 + 32'(4 * i));
      check("t5_refill_waddr", 32'(bus.ram_waddr), 32'(4 + i));
      check("t5_refill_wdata", bus.ram_wdata, 32'h5555_0700 + 32'(4 * i));
    end
    tick();
    settle();
    check("t5_refill_done", 32'(bus.fill_done), 32'd1);
    bus.mem_ready = 1'b0;

    // ---------------- T6: back-to-back reads in IDLE, addresses 0,1,2
    // words 0/1 came from the aborted fill; word 2 was never written
    tick();
    bus.rd_req  = 1'b1;
    bus.rd_addr = 4'd0;
    settle();
    check("t6_gnt0", 32'(bus.rd_gnt), 32'd1);
    tick();
    bus.rd_addr = 4'd1;
    settle();
    check("t6_valid0", 32'(bus.rd_valid), 32'd1);
    check("t6_data0",  bus.rd_data, 32'h5555_0600);
    tick();
    bus.rd_addr = 4'd2;
    settle();
    check("t6_valid1", 32'(bus.rd_valid), 32'd1);
    check("t6_data1",  bus.rd_data, 32'h5555_0604);
    tick();
    bus.rd_req = 1'b0;
    settle();
    check("t6_valid2", 32'(bus.rd_valid), 32'd1);
    check("t6_data2",  bus.rd_data, 32'h2222_2222);
    tick();
    settle();
    check("t6_valid_off", 32'(bus.rd_valid), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
